// File: rtl/timer_pkg.sv
// Shared types and constants for the prescaled up/down timer.
package timer_pkg;

    localparam int unsigned CNT_W = 32;
    localparam int unsigned CKS_W = 2;

    // Prescale select encodings: divide by 2^(cks+1)
    localparam logic [CKS_W-1:0] CKS_DIV2  = 2'd0;
    localparam logic [CKS_W-1:0] CKS_DIV4  = 2'd1;
    localparam logic [CKS_W-1:0] CKS_DIV8  = 2'd2;
    localparam logic [CKS_W-1:0] CKS_DIV16 = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        COUNT = 2'd2
    } state_e;

    // Terminal prescaler value for a given select, i.e. 2^(cks+1)-1
    function automatic logic [3:0] psc_max(input logic [CKS_W-1:0] sel);
        logic [3:0] m;
        case (sel)
            CKS_DIV2:  m = 4'd1;
            CKS_DIV4:  m = 4'd3;
            CKS_DIV8:  m = 4'd7;
            default:   m = 4'd15;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Clock prescaler: free-runs while run is high and emits a one-cycle tick
// on the last count of each period. A change of cks restarts the period.
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int unsigned DIV_W = 4
) (
    input  logic             pclk,
    input  logic             preset_n,
    input  logic             run,
    input  logic [CKS_W-1:0] cks,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_max;
    logic [CKS_W-1:0] cks_q;
    logic             cks_chg;

    // A new cks value is seen for one cycle before cks_q catches up; that
    // cycle clears the count and must not produce a tick.
    assign cks_chg = (cks != cks_q);
    assign cnt_max = DIV_W'(psc_max(cks));
    assign tick    = run && !cks_chg && (cnt == cnt_max);

    // Prescale count and last-seen select
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            cnt   <= '0;
            cks_q <= '0;
        end else begin
            cks_q <= cks;
            if (!run || cks_chg || tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/timer_counter.sv
// 32-bit loadable up/down timer with selectable prescaler and registered
// overflow/underflow pulses.
module timer_counter
    import timer_pkg::*;
#(
    parameter int unsigned DIV_W = 4
) (
    input  logic             pclk,
    input  logic             preset_n,
    input  logic             en,
    input  logic             load,
    input  logic             updown,
    input  logic [CKS_W-1:0] cks,
    input  logic [CNT_W-1:0] tdr,
    output logic [CNT_W-1:0] tcnt,
    output logic             ovf_trig,
    output logic             udf_trig
);

    state_e           state;
    state_e           next_state;
    logic             tick;
    logic             run;
    logic [CNT_W-1:0] tcnt_d;
    logic             ovf_d;
    logic             udf_d;

    assign run = (state == COUNT);

    timer_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .pclk     (pclk),
        .preset_n (preset_n),
        .run      (run),
        .cks      (cks),
        .tick     (tick)
    );

    // Next state and next register values; a tick only counts if this
    // cycle's inputs keep the block in COUNT (load/en drop wins over tick).
    always_comb begin
        next_state = state;
        tcnt_d     = tcnt;
        ovf_d      = 1'b0;
        udf_d      = 1'b0;

        if (load) begin
            next_state = LOAD;
        end else if (en) begin
            next_state = COUNT;
        end else begin
            next_state = IDLE;
        end

        case (next_state)
            LOAD: begin
                tcnt_d = tdr;
            end
            COUNT: begin
                if (tick) begin
                    if (!updown) begin
                        tcnt_d = tcnt + CNT_W'(1);
                        ovf_d  = (tcnt == '1);
                    end else begin
                        tcnt_d = tcnt - CNT_W'(1);
                        udf_d  = (tcnt == '0);
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state    <= IDLE;
            tcnt     <= '0;
            ovf_trig <= 1'b0;
            udf_trig <= 1'b0;
        end else begin
            state    <= next_state;
            tcnt     <= tcnt_d;
            ovf_trig <= ovf_d;
            udf_trig <= udf_d;
        end
    end

endmodule
